// File: rtl/barrel_shifter_pipe.sv
// ============================================================================
//  Module      : barrel_shifter_pipe
//  Description : Pipelined valid/ready barrel shifter. Shifts or rotates a
//                WIDTH-bit operand, with the shift levels split across PIPE
//                register slices.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module barrel_shifter_pipe #(
    parameter int WIDTH = 32,
    parameter int PIPE  = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     IV,
    output logic                     IR,
    input  logic                     LR,
    input  logic                     LA,
    input  logic                     RO,
    input  logic [$clog2(WIDTH)-1:0] W,
    input  logic [WIDTH-1:0]         A,
    output logic                     OV,
    input  logic                     OR,
    output logic [WIDTH-1:0]         Y
);

    localparam int c_lvls = $clog2(WIDTH);

    logic [PIPE-1:0]   r_v;
    logic [PIPE-1:0]   w_ld;
    logic [PIPE-1:0]   w_vin;
    logic [WIDTH-1:0]  w_d_in   [PIPE+1];
    logic [c_lvls-1:0] w_amt_in [PIPE];
    logic              w_lr_in  [PIPE];
    logic              w_la_in  [PIPE];
    logic              w_ro_in  [PIPE];

    // One shift level by a constant distance k (1 .. WIDTH/2).
    function automatic logic [WIDTH-1:0] f_level(
        input logic [WIDTH-1:0] d,
        input int               k,
        input logic             lr,
        input logic             la,
        input logic             ro
    );
        logic [WIDTH-1:0] r;
        if (ro)
            r = lr ? ((d >> k) | (d << (WIDTH - k)))
                   : ((d << k) | (d >> (WIDTH - k)));
        else if (!lr)
            r = d << k;
        else if (la)
            r = $signed(d) >>> k;
        else
            r = d >> k;
        return r;
    endfunction

    assign w_d_in[0]   = A;
    assign w_amt_in[0] = W;
    assign w_lr_in[0]  = LR;
    assign w_la_in[0]  = LA;
    assign w_ro_in[0]  = RO;

    always_comb begin
        w_vin[0] = IV;
        for (int s = 1; s < PIPE; s++)
            w_vin[s] = r_v[s-1];
    end

    // A slice may load when empty or when whatever it holds leaves this cycle;
    // this reduces to ~v[s] | load[s+1], with OR standing in past the last slice.
    always_comb begin : p_ld
        logic w_down;
        w_down = OR;
        for (int s = PIPE - 1; s >= 0; s--) begin
            w_ld[s] = ~r_v[s] | w_down;
            w_down  = w_ld[s];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_v <= '0;
        end else begin
            for (int s = 0; s < PIPE; s++)
                if (w_ld[s])
                    r_v[s] <= w_vin[s];
        end
    end

    for (genvar s = 0; s < PIPE; s++) begin : g_slice
        localparam int c_lo = (s * c_lvls) / PIPE;
        localparam int c_hi = ((s + 1) * c_lvls) / PIPE;

        logic [WIDTH-1:0] w_d;
        logic [WIDTH-1:0] r_d;

        always_comb begin
            w_d = w_d_in[s];
            for (int i = 0; i < c_lvls; i++)
                if (i >= c_lo && i < c_hi && w_amt_in[s][i])
                    w_d = f_level(w_d, 1 << i, w_lr_in[s], w_la_in[s], w_ro_in[s]);
        end

        always_ff @(posedge CLK) begin
            if (w_ld[s] && w_vin[s])
                r_d <= w_d;
        end

        assign w_d_in[s+1] = r_d;

        // The final slice has no downstream level, so it keeps data only.
        if (s < PIPE - 1) begin : g_ctrl
            logic [c_lvls-1:0] r_amt;
            logic              r_lr;
            logic              r_la;
            logic              r_ro;

            always_ff @(posedge CLK) begin
                if (w_ld[s] && w_vin[s]) begin
                    r_amt <= w_amt_in[s];
                    r_lr  <= w_lr_in[s];
                    r_la  <= w_la_in[s];
                    r_ro  <= w_ro_in[s];
                end
            end

            assign w_amt_in[s+1] = r_amt;
            assign w_lr_in[s+1]  = r_lr;
            assign w_la_in[s+1]  = r_la;
            assign w_ro_in[s+1]  = r_ro;
        end
    end

    assign IR = w_ld[0];
    assign OV = r_v[PIPE-1];
    // Data slices are unreset; masking keeps stale data off Y while OV is low.
    assign Y  = w_d_in[PIPE] & {WIDTH{r_v[PIPE-1]}};

endmodule

`default_nettype wire

// File: tb/tb_barrel_shifter_pipe.sv
// ============================================================================
//  Module      : tb_barrel_shifter_pipe
//  Description : Self-checking bench for barrel_shifter_pipe (directed table,
//                handshake sequences, and PIPE=1/5 random sweeps).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_barrel_shifter_pipe;

    typedef struct {
        logic        lr;
        logic        la;
        logic        ro;
        logic [4:0]  w;
        logic [31:0] a;
        logic [31:0] exp;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        iv;
    logic        ir;
    logic        lr;
    logic        la;
    logic        ro;
    logic [4:0]  w;
    logic [31:0] a;
    logic        ov;
    logic        rdy;
    logic [31:0] y;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          rcv = 0;
    int          first_emit = -1;
    int          last_emit = -1;
    bit          last_acc = 0;
    bit          sweep_done [2];
    logic [31:0] q [$];

    barrel_shifter_pipe #(.WIDTH(32), .PIPE(2)) u_dut (
        .CLK(clk), .RST(rst), .IV(iv), .IR(ir), .LR(lr), .LA(la), .RO(ro),
        .W(w), .A(a), .OV(ov), .OR(rdy), .Y(y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: apply the shift one bit position at a time.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] n,
                                              input logic r, input logic ar, input logic rot);
        logic [31:0] t;
        t = d;
        for (int k = 0; k < 32; k++) begin
            if (k < int'(n)) begin
                if (rot)
                    t = r ? {t[0], t[31:1]} : {t[30:0], t[31]};
                else if (r)
                    t = {(ar ? t[31] : 1'b0), t[31:1]};
                else
                    t = {t[30:0], 1'b0};
            end
        end
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic rand_beat();
        a  = $urandom;
        w  = 5'($urandom_range(0, 31));
        lr = 1'($urandom_range(0, 1));
        la = 1'($urandom_range(0, 1));
        ro = 1'($urandom_range(0, 1));
        iv = 1'b1;
    endtask

    // Called just after the inputs are set at a falling edge: settles, then
    // records what the coming rising edge will accept and emit.
    task automatic step();
        #1;
        cyc++;
        last_acc = iv && ir;
        if (ov && rdy) begin
            if (q.size() == 0)
                chk("unexpected_beat", 32'd1, 32'd0);
            else
                chk("stream_y", y, q.pop_front());
            rcv++;
            if (first_emit < 0) first_emit = cyc;
            last_emit = cyc;
        end
        if (last_acc)
            q.push_back(ref_shift(a, w, lr, la, ro));
    endtask

    initial begin
        vec_t tbl [20];

        tbl[0]  = '{1'b1, 1'b1, 1'b0, 5'd4,  32'h80000000, 32'hF8000000};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 5'd1,  32'h80000001, 32'h00000003};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 5'd1,  32'h80000001, 32'hC0000000};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 5'd1,  32'h80000001, 32'h00000002};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 5'd4,  32'h80000001, 32'h00000010};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 5'd4,  32'h80000000, 32'h08000000};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 5'd4,  32'h80000001, 32'h18000000};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 5'd31, 32'h00000001, 32'h80000000};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 5'd31, 32'h80000000, 32'hFFFFFFFF};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 5'd31, 32'hFFFFFFFF, 32'h00000001};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 5'd31, 32'hFFFFFFFF, 32'h80000000};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 5'd8,  32'h7F00FF00, 32'h007F00FF};
        for (int i = 0; i < 8; i++)
            tbl[12+i] = '{i[2], i[1], i[0], 5'd0, 32'hDEADBEEF, 32'hDEADBEEF};

        rst = 1'b1; iv = 1'b0; rdy = 1'b0;
        lr = 1'b0; la = 1'b0; ro = 1'b0; w = '0; a = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_ov", {31'd0, ov}, 32'd0);
        chk("reset_y", y, 32'd0);
        chk("reset_ir", {31'd0, ir}, 32'd1);

        // Directed table: one beat at a time, latency and result checked.
        for (int v = 0; v < 20; v++) begin
            @(negedge clk);
            lr = tbl[v].lr; la = tbl[v].la; ro = tbl[v].ro;
            w = tbl[v].w;   a = tbl[v].a;
            iv = 1'b1; rdy = 1'b1;
            #1;
            chk($sformatf("vec%0d_ir", v), {31'd0, ir}, 32'd1);
            @(negedge clk);
            iv = 1'b0;
            #1;
            chk($sformatf("vec%0d_ov_early", v), {31'd0, ov}, 32'd0);
            @(negedge clk);
            #1;
            chk($sformatf("vec%0d_ov", v), {31'd0, ov}, 32'd1);
            chk($sformatf("vec%0d_y", v), y, tbl[v].exp);
        end

        // Streaming: 16 back-to-back beats with the sink always ready.
        @(negedge clk);
        q.delete(); rcv = 0; first_emit = -1; last_emit = -1; rdy = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            rand_beat();
            step();
            chk("stream_ir", {31'd0, ir}, 32'd1);
        end
        for (int t = 0; t < 10 && rcv < 16; t++) begin
            @(negedge clk);
            iv = 1'b0;
            step();
        end
        chk("stream_count", rcv, 16);
        chk("stream_consecutive", last_emit - first_emit, 15);

        // Backpressure: three beats into a stalled pipe, then drain.
        @(negedge clk);
        q.delete(); rcv = 0; rdy = 1'b0;
        rand_beat(); step();
        chk("bp_acc0", {31'd0, last_acc}, 32'd1);
        @(negedge clk);
        rand_beat(); step();
        chk("bp_acc1", {31'd0, last_acc}, 32'd1);
        @(negedge clk);
        rand_beat(); step();
        chk("bp_ir_low", {31'd0, ir}, 32'd0);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            step();
            chk("bp_ov_hold", {31'd0, ov}, 32'd1);
            chk("bp_y_hold", y, q[0]);
            chk("bp_ir_hold", {31'd0, ir}, 32'd0);
        end
        @(negedge clk);
        rdy = 1'b1;
        step();
        chk("bp_third_accepted", {31'd0, last_acc}, 32'd1);
        for (int t = 0; t < 10 && rcv < 3; t++) begin
            @(negedge clk);
            if (last_acc) iv = 1'b0;
            step();
        end
        chk("bp_count", rcv, 3);

        // Reset with two beats in flight.
        @(negedge clk);
        iv = 1'b0;
        @(negedge clk);
        q.delete(); rcv = 0; rdy = 1'b0;
        rand_beat(); step();
        @(negedge clk);
        rand_beat(); step();
        @(negedge clk);
        iv = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; rdy = 1'b1;
        #1;
        chk("midrst_ov", {31'd0, ov}, 32'd0);
        chk("midrst_y", y, 32'd0);
        chk("midrst_ir", {31'd0, ir}, 32'd1);
        q.delete();
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            step();
        end
        chk("midrst_no_stale", rcv, 0);

        for (int t = 0; t < 50000 && !(sweep_done[0] && sweep_done[1]); t++)
            @(negedge clk);
        if (!(sweep_done[0] && sweep_done[1]))
            chk("sweep_finished", 32'd0, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Random sweeps for the shallowest and deepest pipelines.
    for (genvar g = 0; g < 2; g++) begin : g_sweep
        localparam int P = (g == 0) ? 1 : 5;

        logic        s_rst;
        logic        s_iv;
        logic        s_ir;
        logic        s_lr;
        logic        s_la;
        logic        s_ro;
        logic [4:0]  s_w;
        logic [31:0] s_a;
        logic        s_ov;
        logic        s_or;
        logic [31:0] s_y;

        barrel_shifter_pipe #(.WIDTH(32), .PIPE(P)) u_dut (
            .CLK(clk), .RST(s_rst), .IV(s_iv), .IR(s_ir), .LR(s_lr), .LA(s_la),
            .RO(s_ro), .W(s_w), .A(s_a), .OV(s_ov), .OR(s_or), .Y(s_y)
        );

        initial begin
            logic [31:0] sq [$];
            int          sent;
            int          recv;
            int          scyc;
            bit          acc;

            sent = 0; recv = 0; scyc = 0; acc = 1'b0;
            sweep_done[g] = 1'b0;
            s_rst = 1'b1; s_iv = 1'b0; s_or = 1'b0;
            s_lr = 1'b0; s_la = 1'b0; s_ro = 1'b0; s_w = '0; s_a = '0;
            repeat (3) @(negedge clk);
            s_rst = 1'b0;
            while (recv < 1000 && scyc < 20000) begin
                @(negedge clk);
                scyc++;
                if (acc) s_iv = 1'b0;
                if (!s_iv && sent < 1000 && $urandom_range(0, 3) != 0) begin
                    s_a  = $urandom;
                    s_w  = 5'($urandom_range(0, 31));
                    s_lr = 1'($urandom_range(0, 1));
                    s_la = 1'($urandom_range(0, 1));
                    s_ro = 1'($urandom_range(0, 1));
                    s_iv = 1'b1;
                end
                s_or = 1'($urandom_range(0, 1));
                #1;
                acc = s_iv && s_ir;
                if (s_ov && s_or) begin
                    if (sq.size() == 0)
                        chk($sformatf("sweep_p%0d_extra", P), 32'd1, 32'd0);
                    else
                        chk($sformatf("sweep_p%0d_y", P), s_y, sq.pop_front());
                    recv++;
                end
                if (acc) begin
                    sq.push_back(ref_shift(s_a, s_w, s_lr, s_la, s_ro));
                    sent++;
                end
            end
            if (recv < 1000)
                chk($sformatf("sweep_p%0d_timeout", P), recv, 1000);
            sweep_done[g] = 1'b1;
        end
    end

endmodule

`default_nettype wire
